// File: rtl/uart_io_nios2_qsys_oci_dct_packer.sv
// ---------------------------------------------------------------------------
// uart_io_nios2_qsys_oci_dct_packer
//
// Packs SYM_W-bit OCI data-capture-trace symbols into a live accumulator
// (dct_buffer / dct_count). It commits the accumulator as a frame to a
// downstream sink when any of these happens:
//   - the accumulator is full,
//   - a flush is requested,
//   - the accumulator has been idle for TIMEOUT cycles.
//
// Ports
//   clk          : single rising-edge clock
//   reset_n      : synchronous active-low reset
//   sym_in       : trace symbol
//   sym_valid    : sym_in is valid
//   sym_ready    : the packer takes sym_in when sym_valid && sym_ready
//   flush_req    : level or pulse; asks for a partial buffer to be committed
//   dct_buffer   : live accumulator; slot k is bits [SYM_W*k +: SYM_W]
//   dct_count    : number of symbols in dct_buffer (0..NSYM)
//   frame_valid  : a committed frame is being offered
//   frame_ready  : the sink takes the frame when frame_valid && frame_ready
//   frame_buffer : committed buffer; unused slots read 0
//   frame_count  : number of symbols in the committed frame (1..NSYM)
//   frames_sent  : number of frames committed; wraps at 16 bits
//   busy         : accumulator non-empty, frame held, or flush pending
// ---------------------------------------------------------------------------
module uart_io_nios2_qsys_oci_dct_packer #(
    parameter int SYM_W   = 3,
    parameter int NSYM    = 10,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [SYM_W-1:0]      sym_in,
    input  logic                  sym_valid,
    output logic                  sym_ready,
    input  logic                  flush_req,
    output logic [SYM_W*NSYM-1:0] dct_buffer,
    output logic [3:0]            dct_count,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic [SYM_W*NSYM-1:0] frame_buffer,
    output logic [3:0]            frame_count,
    output logic [15:0]           frames_sent,
    output logic                  busy
);

    localparam int BUF_W = SYM_W * NSYM;
    localparam int IW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

    state_t           state_reg, state_next;
    logic [BUF_W-1:0] buf_reg, buf_next;
    logic [3:0]       cnt_reg, cnt_next;
    logic [3:0]       base_cnt;
    logic [IW-1:0]    idle_cnt_reg, idle_cnt_next;
    logic             flush_pend_reg, flush_pend_next;
    logic             frame_valid_reg;
    logic [BUF_W-1:0] frame_buf_reg;
    logic [3:0]       frame_cnt_reg;
    logic [15:0]      frames_sent_reg;

    logic             accept;
    logic             timeout_hit;
    logic             commit_req;
    logic             out_free;
    logic             commit;
    logic [NSYM-1:0]  slot_wr;

    // HOLD is exactly the full state, so readiness comes straight from a
    // register and never from frame_ready.
    assign sym_ready   = (state_reg != HOLD);
    assign accept      = sym_valid && sym_ready;
    assign timeout_hit = (TIMEOUT != 0) && (idle_cnt_reg == IW'(TIMEOUT));
    assign commit_req  = (cnt_reg == 4'(NSYM))
                       || (flush_pend_reg && (cnt_reg != 4'd0))
                       || timeout_hit;
    assign out_free    = !frame_valid_reg || frame_ready;
    assign commit      = commit_req && out_free;

    // A symbol accepted in the commit cycle starts the new buffer at slot 0.
    assign base_cnt = commit ? 4'd0 : cnt_reg;
    assign cnt_next = base_cnt + {3'd0, accept};

    generate
        for (genvar gi = 0; gi < NSYM; gi++) begin : g_slot
            assign slot_wr[gi] = accept && (base_cnt == 4'(gi));
            assign buf_next[gi*SYM_W +: SYM_W] =
                slot_wr[gi] ? sym_in :
                (commit ? '0 : buf_reg[gi*SYM_W +: SYM_W]);
        end
    endgenerate

    always_comb begin
        idle_cnt_next = idle_cnt_reg;
        if (accept || commit) begin
            idle_cnt_next = '0;
        end else if ((cnt_reg != 4'd0) && (idle_cnt_reg < IW'(TIMEOUT))) begin
            idle_cnt_next = idle_cnt_reg + 1'b1;
        end
    end

    // A flush against an empty accumulator with nothing arriving is dropped
    // rather than left pending, so it cannot produce an empty frame later.
    always_comb begin
        flush_pend_next = flush_pend_reg;
        if (commit) begin
            flush_pend_next = 1'b0;
        end else if ((flush_req || flush_pend_reg) && (cnt_reg == 4'd0) && !accept) begin
            flush_pend_next = 1'b0;
        end else if (flush_req) begin
            flush_pend_next = 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (cnt_next == 4'd0) begin
            state_next = IDLE;
        end else if (cnt_next == 4'(NSYM)) begin
            state_next = HOLD;
        end else begin
            state_next = FILL;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            buf_reg         <= '0;
            cnt_reg         <= '0;
            idle_cnt_reg    <= '0;
            flush_pend_reg  <= 1'b0;
            frame_valid_reg <= 1'b0;
            frame_buf_reg   <= '0;
            frame_cnt_reg   <= '0;
            frames_sent_reg <= '0;
        end else begin
            state_reg      <= state_next;
            buf_reg        <= buf_next;
            cnt_reg        <= cnt_next;
            idle_cnt_reg   <= idle_cnt_next;
            flush_pend_reg <= flush_pend_next;
            if (commit) begin
                frame_valid_reg <= 1'b1;
                frame_buf_reg   <= buf_reg;
                frame_cnt_reg   <= cnt_reg;
                frames_sent_reg <= frames_sent_reg + 16'd1;
            end else if (frame_valid_reg && frame_ready) begin
                frame_valid_reg <= 1'b0;
            end
        end
    end

    assign dct_buffer   = buf_reg;
    assign dct_count    = cnt_reg;
    assign frame_valid  = frame_valid_reg;
    assign frame_buffer = frame_buf_reg;
    assign frame_count  = frame_cnt_reg;
    assign frames_sent  = frames_sent_reg;
    assign busy         = (cnt_reg != 4'd0) || frame_valid_reg || flush_pend_reg;

endmodule
